// File: rtl/lfsr16_pkg.sv
// rtl/lfsr16_pkg.sv - shared types, constants and step function for the 16-bit XNOR Galois LFSR
package lfsr16_pkg;

    localparam int          LFSR_W          = 16;
    localparam logic [15:0] LFSR_LOCKUP     = 16'hFFFF;
    localparam logic [15:0] LFSR_RESET_SEED = 16'h0000;

    localparam int TAP_LO  = 4;
    localparam int TAP_MID = 13;
    localparam int TAP_HI  = 15;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Rotate left, then replace the three tap bits with XNOR against the old MSB.
    function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        n          = {s[LFSR_W-2:0], s[LFSR_W-1]};
        n[TAP_LO]  = ~(s[TAP_LO-1]  ^ s[LFSR_W-1]);
        n[TAP_MID] = ~(s[TAP_MID-1] ^ s[LFSR_W-1]);
        n[TAP_HI]  = ~(s[TAP_HI-1]  ^ s[LFSR_W-1]);
        return n;
    endfunction

    function automatic logic [4:0] popcount16(input logic [LFSR_W-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < LFSR_W; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/lfsr16_err_acc.sv
// rtl/lfsr16_err_acc.sv - saturating word/bit error counters with clear priority
module lfsr16_err_acc #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [4:0]       bit_add,
    output logic [ERR_W-1:0] word_cnt,
    output logic [ERR_W-1:0] bit_cnt
);

    // Sum is wide enough for both operands plus a carry, so the clamp sees overflow.
    localparam int SUM_W = ((ERR_W > 5) ? ERR_W : 5) + 1;
    localparam logic [SUM_W-1:0] SAT = {{(SUM_W-ERR_W){1'b0}}, {ERR_W{1'b1}}};

    logic [SUM_W-1:0] bit_sum;

    assign bit_sum = SUM_W'(bit_cnt) + SUM_W'(bit_add);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word_cnt <= '0;
        end else if (inc && !(&word_cnt)) begin
            word_cnt <= word_cnt + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bit_cnt <= '0;
        end else if (inc) begin
            if (bit_sum > SAT) begin
                bit_cnt <= '1;
            end else begin
                bit_cnt <= bit_sum[ERR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/lfsr16_checker.sv
// rtl/lfsr16_checker.sv - self-seeding lock/verify checker for the lfsr16 pseudo-random stream
module lfsr16_checker
    import lfsr16_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic              lockup_det,
    output logic [ERR_W-1:0]  word_err_cnt,
    output logic [ERR_W-1:0]  bit_err_cnt
);

    chk_state_t        state_q, state_d;
    logic [LFSR_W-1:0] pred_q, pred_d;
    logic [7:0]        match_q, match_d;
    logic [7:0]        miss_q, miss_d;
    logic              locked_q, err_q, lockup_q;
    logic              is_lockup, mism;
    logic [4:0]        acc_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            pred_q   <= LFSR_RESET_SEED;
            match_q  <= 8'd0;
            miss_q   <= 8'd0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= mism;
            lockup_q <= is_lockup;
        end
    end

    // HUNT/VERIFY reseed from the received word; LOCKED only flywheels its own prediction.
    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        match_d   = match_q;
        miss_d    = miss_q;
        mism      = 1'b0;
        is_lockup = data_valid && (data_in == LFSR_LOCKUP);
        if (data_valid) begin
            case (state_q)
                HUNT: begin
                    if (!is_lockup) begin
                        pred_d  = lfsr16_next(data_in);
                        match_d = 8'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_lockup) begin
                        state_d = HUNT;
                    end else if (data_in == pred_q) begin
                        pred_d  = lfsr16_next(data_in);
                        match_d = match_q + 8'd1;
                        if (match_d == 8'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            miss_d  = 8'd0;
                        end
                    end else begin
                        pred_d  = lfsr16_next(data_in);
                        match_d = 8'd0;
                    end
                end
                LOCKED: begin
                    pred_d = lfsr16_next(pred_q);
                    if (data_in == pred_q) begin
                        miss_d = 8'd0;
                    end else begin
                        mism   = 1'b1;
                        miss_d = miss_q + 8'd1;
                        if (miss_d == 8'(LOSS_CNT)) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign acc_bits = mism ? popcount16(data_in ^ pred_q) : 5'd0;

    lfsr16_err_acc #(
        .ERR_W (ERR_W)
    ) u_err_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_cnt),
        .inc      (mism),
        .bit_add  (acc_bits),
        .word_cnt (word_err_cnt),
        .bit_cnt  (bit_err_cnt)
    );

    assign locked     = locked_q;
    assign err_pulse  = err_q;
    assign lockup_det = lockup_q;

endmodule
